// File: rtl/fp_div_seq_if.sv
// fp_div_seq_if: request/result bundle for the sequential float divider.
//   start        request strobe, sampled only while the divider is idle
//   a, b         dividend / divisor, IEEE-754 single
//   busy         division in progress
//   done         one-cycle result strobe
//   out          quotient, held until the next done
//   div_by_zero  nonzero dividend over a zero divisor, held with out
interface fp_div_seq_if;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [31:0] out;
  logic        div_by_zero;

  modport master (output start, a, b, input busy, done, out, div_by_zero);
  modport slave  (input start, a, b, output busy, done, out, div_by_zero);
endinterface

// File: rtl/fp_div_seq.sv
// fp_div_seq: sequential IEEE-754 single-precision divider, out = a / b.
// Radix-2 restoring mantissa division producing one quotient bit per clock.
// The number format has an implicit leading 1 with no denormal, NaN or Inf
// decoding. Results are truncated, and underflow flushes to +0.
// Ports:
//   clk    clock, all state updates on the rising edge
//   rst_n  synchronous active-low reset, aborts any division in flight
//   bus    fp_div_seq_if.slave (start/a/b in, busy/done/out/div_by_zero out)
module fp_div_seq #(
  parameter logic [7:0] BIAS = 8'd127
) (
  input logic          clk,
  input logic          rst_n,
  fp_div_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  state_t              state_q, state_d;
  logic [4:0]          cnt_q, cnt_d;
  logic [24:0]         rem_q, rem_d;
  logic [24:0]         quo_q, quo_d;
  logic [23:0]         mb_q, mb_d;
  logic                sign_q, sign_d;
  logic [7:0]          ea_q, ea_d;
  logic [7:0]          eb_q, eb_d;
  logic                zero_q, zero_d;     // special: a is zero
  logic                dbz_flag_q, dbz_flag_d; // special: nonzero a over zero b
  logic [31:0]         out_q, out_d;
  logic                dbz_q, dbz_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [24:0]         diff;
  logic signed [9:0]   exp_s;
  logic [22:0]         mant;

  // Saturating pack: non-positive exponent flushes to +0 (sign dropped),
  // exponent at or above 255 saturates to signed infinity.
  function automatic logic [31:0] pack_result(input logic sign,
                                              input logic signed [9:0] e,
                                              input logic [22:0] m);
    if (e <= 10'sd0)
      pack_result = 32'h0000_0000;
    else if (e >= 10'sd255)
      pack_result = {sign, 8'hFF, 23'h0};
    else
      pack_result = {sign, e[7:0], m};
  endfunction

  assign diff = rem_q - {1'b0, mb_q};

  // Quotient lies in (0.5, 2): bit 24 tells whether one normalising shift is needed.
  always_comb begin
    exp_s = $signed({2'b00, ea_q}) - $signed({2'b00, eb_q}) + $signed({2'b00, BIAS});
    mant  = quo_q[23:1];
    if (!quo_q[24]) begin
      exp_s = exp_s - 10'sd1;
      mant  = quo_q[22:0];
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rem_d      = rem_q;
    quo_d      = quo_q;
    mb_d       = mb_q;
    sign_d     = sign_q;
    ea_d       = ea_q;
    eb_d       = eb_q;
    zero_d     = zero_q;
    dbz_flag_d = dbz_flag_q;
    out_d      = out_q;
    dbz_d      = dbz_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          sign_d     = bus.a[31] ^ bus.b[31];
          ea_d       = bus.a[30:23];
          eb_d       = bus.b[30:23];
          mb_d       = {1'b1, bus.b[22:0]};
          rem_d      = {2'b01, bus.a[22:0]};
          quo_d      = 25'd0;
          cnt_d      = 5'd0;
          busy_d     = 1'b1;
          zero_d     = (bus.a[30:0] == 31'd0);
          dbz_flag_d = (bus.a[30:0] != 31'd0) && (bus.b[30:0] == 31'd0);
          // Specials skip the mantissa loop; NORM publishes them one edge later.
          if ((bus.a[30:0] == 31'd0) || (bus.b[30:0] == 31'd0))
            state_d = NORM;
          else
            state_d = DIV;
        end
      end
      DIV: begin
        // rem stays below 2*Mb < 2^25, so dropping the top bit before the shift is lossless.
        if (rem_q >= {1'b0, mb_q}) begin
          quo_d = {quo_q[23:0], 1'b1};
          rem_d = {diff[23:0], 1'b0};
        end else begin
          quo_d = {quo_q[23:0], 1'b0};
          rem_d = {rem_q[23:0], 1'b0};
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd24)
          state_d = NORM;
      end
      NORM: begin
        if (zero_q) begin
          out_d = 32'h0000_0000;
          dbz_d = 1'b0;
        end else if (dbz_flag_q) begin
          out_d = {sign_q, 8'hFF, 23'h0};
          dbz_d = 1'b1;
        end else begin
          out_d = pack_result(sign_q, exp_s, mant);
          dbz_d = 1'b0;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= 5'd0;
      out_q      <= 32'h0000_0000;
      dbz_q      <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      zero_q     <= 1'b0;
      dbz_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      out_q      <= out_d;
      dbz_q      <= dbz_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      zero_q     <= zero_d;
      dbz_flag_q <= dbz_flag_d;
    end
  end

  // Datapath registers carry no reset; they are always loaded before use.
  always_ff @(posedge clk) begin
    rem_q  <= rem_d;
    quo_q  <= quo_d;
    mb_q   <= mb_d;
    sign_q <= sign_d;
    ea_q   <= ea_d;
    eb_q   <= eb_d;
  end

  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.out         = out_q;
  assign bus.div_by_zero = dbz_q;

endmodule
